// File: rtl/dmi_uart_host.sv
// Host-side initiator for the escape-framed UART debug link: turns DMI requests into
// command/address/data bytes on the TX side and parses data plus status from the RX side.
module dmi_uart_host #(
  parameter int unsigned WIDTH     = 41,
  parameter int unsigned IRLENGTH  = 5,
  parameter logic [7:0]  CMD_READ  = 8'h01,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [IRLENGTH-1:0] req_address,
  input  logic [WIDTH-1:0]    req_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic [2:0]          rsp_status,
  input  logic                tx_ready,
  output logic                write,
  output logic [7:0]          data_send,
  output logic                send_command,
  output logic [7:0]          command,
  output logic                read,
  input  logic [7:0]          data_rec,
  input  logic                rx_empty,
  input  logic                cmd_rec
);

  localparam int unsigned NBYTES = (WIDTH + 7) / 8;
  localparam int unsigned SHW    = NBYTES * 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_CMD, SEND_ADDR, SEND_DATA, RECV_DATA, RECV_STATUS, RESPOND
  } state_t;

  state_t              state_reg;
  logic                is_write_reg;
  logic [IRLENGTH-1:0] addr_reg;
  logic [SHW-1:0]      shift_reg;
  logic [CW-1:0]       byte_cnt_reg;
  logic [TW-1:0]       timer_reg;
  logic                rx_active;
  logic                link_err;

  // IDLE only drains stray bytes once req_ready is up, so nothing is popped during reset.
  assign rx_active = req_ready || (state_reg == RECV_DATA) || (state_reg == RECV_STATUS);
  assign read      = rx_active && !rx_empty;
  assign link_err  = (read && cmd_rec) || (!read && (timer_reg == LAST_TICK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      is_write_reg <= 1'b0;
      addr_reg     <= '0;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      timer_reg    <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_status   <= '0;
      write        <= 1'b0;
      data_send    <= '0;
      send_command <= 1'b0;
      command      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready    <= 1'b0;
            is_write_reg <= req_write;
            addr_reg     <= req_address;
            shift_reg    <= SHW'(req_data);
            send_command <= 1'b1;
            command      <= req_write ? CMD_WRITE : CMD_READ;
            state_reg    <= SEND_CMD;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEND_CMD: begin
          if (tx_ready) begin
            send_command <= 1'b0;
            write        <= 1'b1;
            data_send    <= 8'(addr_reg);
            state_reg    <= SEND_ADDR;
          end
        end
        SEND_ADDR: begin
          if (tx_ready) begin
            byte_cnt_reg <= '0;
            timer_reg    <= '0;
            if (is_write_reg) begin
              data_send <= shift_reg[7:0];
              shift_reg <= {8'h00, shift_reg[SHW-1:8]};
              state_reg <= SEND_DATA;
            end else begin
              write     <= 1'b0;
              state_reg <= RECV_DATA;
            end
          end
        end
        SEND_DATA: begin
          if (tx_ready) begin
            if (byte_cnt_reg == LAST_BYTE) begin
              write     <= 1'b0;
              timer_reg <= '0;
              state_reg <= RECV_STATUS;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CW'(1);
              data_send    <= shift_reg[7:0];
              shift_reg    <= {8'h00, shift_reg[SHW-1:8]};
            end
          end
        end
        RECV_DATA, RECV_STATUS: begin
          if (link_err) begin
            rsp_status <= 3'b100;
            rsp_data   <= '0;
            rsp_valid  <= 1'b1;
            state_reg  <= RESPOND;
          end else if (read) begin
            timer_reg <= '0;
            if (state_reg == RECV_DATA) begin
              // The TX shift register is idle during reads, so it collects RX bytes LSB first.
              shift_reg <= {data_rec, shift_reg[SHW-1:8]};
              if (byte_cnt_reg == LAST_BYTE) begin
                state_reg <= RECV_STATUS;
              end else begin
                byte_cnt_reg <= byte_cnt_reg + CW'(1);
              end
            end else begin
              rsp_status <= {1'b0, data_rec[1:0]};
              rsp_data   <= is_write_reg ? '0 : shift_reg[WIDTH-1:0];
              rsp_valid  <= 1'b1;
              state_reg  <= RESPOND;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_uart_host.sv
// Scoreboard bench for dmi_uart_host: expected TX bytes and responses are queued by the
// stimulus, and a negedge monitor pops and compares them as the DUT produces them.
module tb_dmi_uart_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_address = '0;
  logic [40:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [40:0] rsp_data;
  logic [2:0]  rsp_status;
  logic        tx_ready = 1'b1;
  logic        write;
  logic [7:0]  data_send;
  logic        send_command;
  logic [7:0]  command;
  logic        read;
  logic [7:0]  data_rec = '0;
  logic        rx_empty = 1'b1;
  logic        cmd_rec = 1'b0;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;

  logic [8:0]  exp_tx[$];
  logic [43:0] exp_rsp[$];
  logic [8:0]  rx_q[$];

  always #5 clk = ~clk;

  dmi_uart_host #(.WIDTH(41), .IRLENGTH(5), .CMD_READ(8'h01), .CMD_WRITE(8'h02), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .tx_ready(tx_ready), .write(write), .data_send(data_send),
    .send_command(send_command), .command(command),
    .read(read), .data_rec(data_rec), .rx_empty(rx_empty), .cmd_rec(cmd_rec)
  );

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // RX FIFO model: fall-through head, popped on the edge after READ was seen high.
  logic popped;
  initial begin
    forever begin
      @(negedge clk);
      popped = read;
      @(posedge clk);
      #2;
      if (popped && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_q.size() > 0) begin
        {cmd_rec, data_rec} = rx_q[0];
        rx_empty = 1'b0;
      end else begin
        {cmd_rec, data_rec} = 9'h000;
        rx_empty = 1'b1;
      end
    end
  end

  logic [8:0]  tx_got;
  logic [8:0]  tx_exp;
  logic [43:0] rsp_cur;
  logic [43:0] rsp_exp;
  logic [43:0] held_val = '0;
  logic        held = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (write || send_command) check("strobe_exclusive", {63'd0, write && send_command}, 64'd0);
      if (read) check("read_while_empty", {63'd0, rx_empty}, 64'd0);
      if (tx_ready && (write || send_command)) begin
        tx_got = {send_command, send_command ? command : data_send};
        tx_count++;
        $display("tx %s %h", send_command ? "cmd " : "data", tx_got[7:0]);
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", {55'd0, tx_got}, 64'h1FF);
        end else begin
          tx_exp = exp_tx.pop_front();
          check("tx_byte", {55'd0, tx_got}, {55'd0, tx_exp});
        end
      end
      if (rsp_valid) begin
        rsp_cur = {rsp_status, rsp_data};
        if (held) check("rsp_stable", {20'd0, rsp_cur}, {20'd0, held_val});
        if (rsp_ready) begin
          $display("rsp status=%b data=%h", rsp_status, rsp_data);
          if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", {20'd0, rsp_cur}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            rsp_exp = exp_rsp.pop_front();
            check("rsp", {20'd0, rsp_cur}, {20'd0, rsp_exp});
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = rsp_cur;
        end
      end else begin
        if (held) check("rsp_dropped", 64'd0, 64'd1);
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_req(input logic wr, input logic [4:0] a, input logic [40:0] d);
    int n = 0;
    @(posedge clk);
    #1;
    req_write = wr;
    req_address = a;
    req_data = d;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrives", {63'd0, rsp_valid}, 64'd1);
    if (rsp_valid) begin
      repeat (hold) @(posedge clk);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic push_rx(input logic c, input logic [7:0] b);
    rx_q.push_back({c, b});
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {req_ready, rsp_valid, write, send_command, read, data_send, command, rsp_status},
          64'd0);
    check({nm, "_rsp_data"}, {23'd0, rsp_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  int n;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // 1: write, LSB-first data bytes, status 00
    exp_tx.push_back(9'h102); exp_tx.push_back(9'h011);
    exp_tx.push_back(9'h0AB); exp_tx.push_back(9'h089); exp_tx.push_back(9'h067);
    exp_tx.push_back(9'h045); exp_tx.push_back(9'h023); exp_tx.push_back(9'h001);
    exp_rsp.push_back({3'b000, 41'h0});
    send_req(1'b1, 5'h11, 41'h1_2345_6789_AB);
    push_rx(1'b0, 8'h00);
    get_rsp(0);

    // 2: read, top bits of last byte discarded, status 02
    exp_tx.push_back(9'h101); exp_tx.push_back(9'h010);
    exp_rsp.push_back({3'b010, 41'h1_0011_2233_44});
    send_req(1'b0, 5'h10, 41'h0);
    push_rx(1'b0, 8'h44); push_rx(1'b0, 8'h33); push_rx(1'b0, 8'h22);
    push_rx(1'b0, 8'h11); push_rx(1'b0, 8'h00); push_rx(1'b0, 8'h01);
    push_rx(1'b0, 8'h02);
    get_rsp(0);

    // 3: read with silent RX -> timeout link error
    exp_tx.push_back(9'h101); exp_tx.push_back(9'h005);
    exp_rsp.push_back({3'b100, 41'h0});
    send_req(1'b0, 5'h05, 41'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    check("timeout_latency_in_range", {63'd0, (n >= 17 && n <= 20)}, 64'd1);
    get_rsp(0);

    // 4: escaped command on the third RX byte -> link error, byte consumed
    exp_tx.push_back(9'h101); exp_tx.push_back(9'h00A);
    exp_rsp.push_back({3'b100, 41'h0});
    send_req(1'b0, 5'h0A, 41'h0);
    push_rx(1'b0, 8'h44); push_rx(1'b0, 8'h33); push_rx(1'b1, 8'h5A);
    get_rsp(0);
    @(negedge clk);
    check("ready_after_link_err", {63'd0, req_ready}, 64'd1);
    check("cmd_byte_consumed", 64'(rx_q.size()), 64'd0);

    // 5: TX_READY toggling during a write; status byte upper bits ignored
    exp_tx.push_back(9'h102); exp_tx.push_back(9'h01F);
    exp_tx.push_back(9'h076); exp_tx.push_back(9'h098); exp_tx.push_back(9'h0BA);
    exp_tx.push_back(9'h0DC); exp_tx.push_back(9'h0FE); exp_tx.push_back(9'h000);
    exp_rsp.push_back({3'b011, 41'h0});
    tx_count = 0;
    fork
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          tx_ready = ~tx_ready;
        end
      end
      begin
        send_req(1'b1, 5'h1F, 41'h0_FEDC_BA98_76);
        push_rx(1'b0, 8'hFF);
        get_rsp(0);
      end
    join
    tx_ready = 1'b1;
    check("toggle_transfers", 64'(tx_count), 64'd8);

    // 6: asynchronous reset in the middle of SEND_DATA, then a read with a stalled consumer
    exp_tx.push_back(9'h102); exp_tx.push_back(9'h003);
    exp_tx.push_back(9'h0EE); exp_tx.push_back(9'h0DD); exp_tx.push_back(9'h0CC);
    exp_tx.push_back(9'h0BB); exp_tx.push_back(9'h0AA); exp_tx.push_back(9'h000);
    tx_count = 0;
    send_req(1'b1, 5'h03, 41'h0_AABB_CCDD_EE);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("transfers_before_reset", 64'(tx_count), 64'd3);
    exp_tx.delete();
    rx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    exp_tx.push_back(9'h101); exp_tx.push_back(9'h01C);
    exp_rsp.push_back({3'b001, 41'h0_0504_0302_01});
    send_req(1'b0, 5'h1C, 41'h0);
    push_rx(1'b0, 8'h01); push_rx(1'b0, 8'h02); push_rx(1'b0, 8'h03);
    push_rx(1'b0, 8'h04); push_rx(1'b0, 8'h05); push_rx(1'b0, 8'h06);
    push_rx(1'b0, 8'h01);
    get_rsp(10);

    // Stray RX byte in IDLE is drained without a response
    push_rx(1'b0, 8'h77);
    repeat (4) @(posedge clk);
    #1;
    check("stray_drained", 64'(rx_q.size()), 64'd0);

    repeat (5) @(posedge clk);
    check("tx_left_over", 64'(exp_tx.size()), 64'd0);
    check("rsp_left_over", 64'(exp_rsp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
